// File: rtl/proc_mem_ctrl.sv
// Program/data memory and fetch sequencer feeding a simple multi-cycle processor.
// Define HALT_DETECT_EN to make opcode 4'b1111 stop execution in a HALT state.
module proc_mem_ctrl #(
    parameter int unsigned ADDR_W = 7
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic [15:0]       addr,
    input  logic [15:0]       BusWires,
    input  logic              store,
    input  logic              Done,
    output logic [15:0]       DIN,
    output logic [15:0]       mem,
    output logic              Run,
    output logic              Halted,
    output logic [ADDR_W-1:0] pc
);

    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PcOne = 1;
    localparam logic [3:0] OpMvi = 4'b0001;

    typedef enum logic [1:0] {StIdle, StIssue, StExec, StHalt} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [3:0]        opcode_q;
    logic [15:0]       mem_q;
    logic [15:0]       ram [Depth];

    logic [15:0] ram_pc;
    logic        active;
    logic        halt_hit;
    logic        addr_ok;

    assign ram_pc  = ram[pc_q];
    assign active  = (state_q == StIssue) || (state_q == StExec);
    // Upper address bits must be clear; out-of-range stores never alias.
    assign addr_ok = (addr >> ADDR_W) == 16'd0;

`ifdef HALT_DETECT_EN
    assign halt_hit = (state_q == StIssue) && (ram_pc[3:0] == 4'b1111);
    assign Halted   = (state_q == StHalt);
`else
    assign halt_hit = 1'b0;
    assign Halted   = 1'b0;
`endif

    assign Run = active && !halt_hit;
    assign DIN = active ? ram_pc : 16'h0000;
    assign pc  = pc_q;
    assign mem = mem_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            opcode_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        state_q <= StIssue;
                        pc_q    <= '0;
                    end
                end
                StIssue: begin
                    if (halt_hit) begin
                        state_q <= StHalt;
                    end else begin
                        opcode_q <= ram_pc[3:0];
                        pc_q     <= pc_q + PcOne;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    if (Done) begin
                        if (opcode_q == OpMvi) begin
                            pc_q <= pc_q + PcOne;
                        end
                        state_q <= StIssue;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mem_q <= 16'h0000;
        end else begin
            mem_q <= ram[addr[ADDR_W-1:0]];
        end
    end

    // No reset on the array: the loaded program must survive Reset.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if ((state_q == StIdle) && prog_we) begin
                ram[prog_addr] <= prog_data;
            end else if (active && store && addr_ok) begin
                ram[addr[ADDR_W-1:0]] <= BusWires;
            end
        end
    end

endmodule

// File: tb/tb_proc_mem_ctrl.sv
// Self-checking bench for proc_mem_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the controller.
module tb_proc_mem_ctrl;

    localparam int AW = 7;
    localparam int DEPTH = 128;
`ifdef HALT_DETECT_EN
    localparam bit HD = 1'b1;
`else
    localparam bit HD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [15:0]   prog_data = '0;
    logic [15:0]   addr = '0;
    logic [15:0]   bus = '0;
    logic          store = 1'b0;
    logic          done = 1'b0;
    logic [15:0]   DIN;
    logic [15:0]   mem;
    logic          Run;
    logic          Halted;
    logic [AW-1:0] pc;

    int checks = 0;
    int failures = 0;

    // Model: RAM image plus what the controller is doing right now.
    logic [15:0]   m_ram [DEPTH];
    bit            m_fetch;
    bit            m_exec;
    bit            m_halt;
    logic [AW-1:0] m_pc;
    logic [3:0]    m_op;
    logic [15:0]   m_mem;

    proc_mem_ctrl #(.ADDR_W(AW)) dut (
        .Clock    (clk),
        .Reset    (rst),
        .Start    (start),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data),
        .addr     (addr),
        .BusWires (bus),
        .store    (store),
        .Done     (done),
        .DIN      (DIN),
        .mem      (mem),
        .Run      (Run),
        .Halted   (Halted),
        .pc       (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch = 1'b0;
        m_exec  = 1'b0;
        m_halt  = 1'b0;
        m_pc    = '0;
        m_op    = '0;
        m_mem   = 16'h0000;
    endtask

    // Check outputs mid-cycle, advance the model, clock once, drop one-cycle pulses.
    task automatic tick();
        logic        running;
        logic        halt_now;
        logic [15:0] instr;
        #2;
        running  = m_fetch || m_exec;
        instr    = m_ram[m_pc];
        halt_now = HD && m_fetch && (instr[3:0] == 4'hF);
        chk("din", DIN, running ? instr : 16'h0000);
        chk("run", {15'b0, Run}, {15'b0, running && !halt_now});
        chk("halted", {15'b0, Halted}, {15'b0, m_halt});
        chk("pc", {9'b0, pc}, {9'b0, m_pc});
        chk("mem", mem, m_mem);
        if (rst) begin
            model_reset();
        end else begin
            m_mem = m_ram[addr[AW-1:0]];
            if (!running && !m_halt && prog_we) m_ram[prog_addr] = prog_data;
            if (running && store && addr < 16'(DEPTH)) m_ram[addr[AW-1:0]] = bus;
            if (!running && !m_halt) begin
                if (start) begin
                    m_fetch = 1'b1;
                    m_pc    = '0;
                end
            end else if (m_fetch) begin
                m_fetch = 1'b0;
                if (halt_now) begin
                    m_halt = 1'b1;
                end else begin
                    m_op   = instr[3:0];
                    m_pc   = m_pc + 7'd1;
                    m_exec = 1'b1;
                end
            end else if (m_exec && done) begin
                if (m_op == 4'b0001) m_pc = m_pc + 7'd1;
                m_exec  = 1'b0;
                m_fetch = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0; prog_we = 1'b0; store = 1'b0; done = 1'b0;
    endtask

    task automatic load(input int a, input logic [15:0] d);
        prog_we   = 1'b1;
        prog_addr = AW'(a);
        prog_data = d;
        tick();
    endtask

    initial begin
        logic [15:0] d;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_ram[i] = 16'hxxxx;

        // Fill RAM with random words that never decode as the halt opcode.
        for (int i = 0; i < DEPTH; i++) begin
            d = 16'($urandom);
            if (d[3:0] == 4'hF) d[3:0] = 4'hE;
            load(i, d);
        end
        #1;
        chk("rst_pc", {9'b0, pc}, 16'd0);
        chk("rst_run", {15'b0, Run}, 16'd0);
        chk("rst_din", DIN, 16'h0000);

        // mv: DIN in ISSUE, pc holds at 1 after Done
        load(0, 16'h0080);
        start = 1'b1; tick();
        #1; chk("s1_issue_din", DIN, 16'h0080);
        chk("s1_issue_run", {15'b0, Run}, 16'd1);
        tick();
        done = 1'b1; tick();
        #1; chk("s1_pc", {9'b0, pc}, 16'd1);

        // mvi: immediate visible in EXEC, pc advances to 2
        rst = 1'b1; tick();
        load(0, 16'h0021);
        load(1, 16'h1234);
        start = 1'b1; tick();
        tick();
        #1; chk("s2_exec_din", DIN, 16'h1234);
        done = 1'b1; tick();
        #1; chk("s2_pc", {9'b0, pc}, 16'd2);

        // store then readback with one cycle of latency
        store = 1'b1; addr = 16'h0040; bus = 16'hBEEF; tick();
        tick();
        #1; chk("s3_mem", mem, 16'hBEEF);

        // out-of-range store must not alias onto word 0
        store = 1'b1; addr = 16'h0100; bus = 16'h5A5A; tick();
        addr = 16'h0000; tick();
        tick();
        #1; chk("s4_no_alias", mem, 16'h0021);

        // reset in EXEC at pc=5, program survives and restarts at word 0
        rst = 1'b1; tick();
        load(0, 16'h0021); load(1, 16'h1111); load(2, 16'h0021);
        load(3, 16'h2222); load(4, 16'h0080);
        start = 1'b1; tick();
        tick();
        done = 1'b1; tick();
        tick();
        done = 1'b1; tick();
        tick();
        #1; chk("s6_pc_exec", {9'b0, pc}, 16'd5);
        rst = 1'b1; start = 1'b1; done = 1'b1; store = 1'b1; tick();
        #1; chk("s6_rst_pc", {9'b0, pc}, 16'd0);
        chk("s6_rst_run", {15'b0, Run}, 16'd0);
        chk("s6_rst_din", DIN, 16'h0000);
        start = 1'b1; tick();
        #1; chk("s6_restart_din", DIN, 16'h0021);

        // halt opcode at word 2
        rst = 1'b1; tick();
        load(0, 16'h0080); load(1, 16'h0080); load(2, 16'h000F);
        start = 1'b1; tick();
        tick();
        done = 1'b1; tick();
        tick();
        done = 1'b1; tick();
        #1;
`ifdef HALT_DETECT_EN
        chk("s5_run_falls", {15'b0, Run}, 16'd0);
        tick();
        #1; chk("s5_halted", {15'b0, Halted}, 16'd1);
        chk("s5_pc", {9'b0, pc}, 16'd2);
        start = 1'b1; tick();
        #1; chk("s5_start_ignored", {15'b0, Halted}, 16'd1);
        chk("s5_run_low", {15'b0, Run}, 16'd0);
`else
        chk("s5_issue_run", {15'b0, Run}, 16'd1);
        chk("s5_issue_din", DIN, 16'h000F);
        tick();
        #1; chk("s5_not_halted", {15'b0, Halted}, 16'd0);
        chk("s5_pc", {9'b0, pc}, 16'd3);
`endif

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            start     = ($urandom_range(0, 3) == 0);
            done      = 1'($urandom_range(0, 1));
            store     = ($urandom_range(0, 2) == 0);
            addr      = ($urandom_range(0, 7) == 0) ? 16'($urandom) : {9'b0, 7'($urandom)};
            bus       = 16'($urandom);
            prog_we   = 1'($urandom_range(0, 1));
            prog_addr = AW'($urandom);
            prog_data = 16'($urandom);
            tick();
        end

        // sweep every word back through mem against the model image
        rst = 1'b1; tick();
        for (int i = 0; i < DEPTH; i++) begin
            addr = 16'(i);
            tick();
        end
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
